// File: rtl/avalon_crypto_regbank.sv
// Avalon-MM slave register bank and start/done sequencer for the lab crypto cores.
// Holds key and message, launches the core, captures its result and raises IRQ.
module avalon_crypto_regbank #(
  parameter int DATA_W    = 32,
  parameter int KEY_WORDS = 4,
  parameter int MSG_WORDS = 4,
  parameter int ADDR_W    = 4
) (
  input  logic                          CLK,
  input  logic                          RESET_N,
  input  logic                          AVL_READ,
  input  logic                          AVL_WRITE,
  input  logic                          AVL_CS,
  input  logic [DATA_W/8-1:0]           AVL_BYTE_EN,
  input  logic [ADDR_W-1:0]             AVL_ADDR,
  input  logic [DATA_W-1:0]             AVL_WRITEDATA,
  output logic [DATA_W-1:0]             AVL_READDATA,
  output logic [KEY_WORDS*DATA_W-1:0]   CORE_KEY,
  output logic [MSG_WORDS*DATA_W-1:0]   CORE_MSG,
  output logic                          CORE_START,
  input  logic [MSG_WORDS*DATA_W-1:0]   CORE_RESULT,
  input  logic                          CORE_DONE,
  output logic                          IRQ,
  output logic [DATA_W-1:0]             EXPORT_DATA
);

  localparam int NB   = DATA_W / 8;
  localparam int HALF = DATA_W / 2;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [ADDR_W-1:0] CTRL_ADDR   = {{(ADDR_W-1){1'b1}}, 1'b0};
  localparam logic [ADDR_W-1:0] STATUS_ADDR = {ADDR_W{1'b1}};

  logic [DATA_W-1:0] key_q [KEY_WORDS];
  logic [DATA_W-1:0] msg_q [MSG_WORDS];
  logic [DATA_W-1:0] res_q [MSG_WORDS];
  logic [1:0]        state_q, state_d;
  logic              start_q, start_d;
  logic              err_q, err_d;
  logic              irq_en_q, irq_en_d;
  logic              irq_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic                 wr_en, rd_en, busy, done, ctrl_wr, status_wr, start_req, capture;
  logic [KEY_WORDS-1:0] key_sel;
  logic [MSG_WORDS-1:0] msg_sel;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                    input logic [DATA_W-1:0] new_v,
                                                    input logic [NB-1:0]     be);
    logic [DATA_W-1:0] r;
    for (int b = 0; b < NB; b++)
      r[b*8 +: 8] = be[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    return r;
  endfunction

  assign wr_en     = AVL_CS & AVL_WRITE;
  assign rd_en     = AVL_CS & AVL_READ;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign ctrl_wr   = wr_en & (AVL_ADDR == CTRL_ADDR) & AVL_BYTE_EN[0];
  assign status_wr = wr_en & (AVL_ADDR == STATUS_ADDR) & AVL_BYTE_EN[0];
  assign start_req = ctrl_wr & AVL_WRITEDATA[0];
  assign capture   = busy & CORE_DONE;

  for (genvar gi = 0; gi < KEY_WORDS; gi++) begin : g_key
    assign key_sel[gi] = (AVL_ADDR == ADDR_W'(gi));
    assign CORE_KEY[(KEY_WORDS-1-gi)*DATA_W +: DATA_W] = key_q[gi];
  end

  for (genvar gi = 0; gi < MSG_WORDS; gi++) begin : g_msg
    assign msg_sel[gi] = (AVL_ADDR == ADDR_W'(KEY_WORDS + gi));
    assign CORE_MSG[(MSG_WORDS-1-gi)*DATA_W +: DATA_W] = msg_q[gi];
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      for (int i = 0; i < MSG_WORDS; i++) msg_q[i] <= '0;
      for (int i = 0; i < MSG_WORDS; i++) res_q[i] <= '0;
    end else begin
      // Key/message writes are locked out while the core consumes them.
      for (int i = 0; i < KEY_WORDS; i++)
        if (wr_en && !busy && key_sel[i])
          key_q[i] <= merge_bytes(key_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
      for (int i = 0; i < MSG_WORDS; i++)
        if (wr_en && !busy && msg_sel[i])
          msg_q[i] <= merge_bytes(msg_q[i], AVL_WRITEDATA, AVL_BYTE_EN);
      if (capture)
        for (int i = 0; i < MSG_WORDS; i++)
          res_q[i] <= CORE_RESULT[(MSG_WORDS-1-i)*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = 1'b0;
    err_d    = err_q;
    irq_en_d = irq_en_q;
    if (ctrl_wr) irq_en_d = AVL_WRITEDATA[1];
    if (status_wr && AVL_WRITEDATA[2]) err_d = 1'b0;
    if (wr_en && busy && ((|key_sel) || (|msg_sel))) err_d = 1'b1;
    case (state_q)
      S_IDLE: if (start_req) begin
        state_d = S_RUN;
        start_d = 1'b1;
      end
      S_RUN: begin
        // Capture beats a concurrent STATUS clear; a start here is an error.
        if (capture) state_d = S_DONE;
        if (start_req) err_d = 1'b1;
      end
      S_DONE: begin
        if (start_req) begin
          state_d = S_RUN;
          start_d = 1'b1;
        end else if (status_wr && AVL_WRITEDATA[0]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    for (int i = 0; i < KEY_WORDS; i++)
      if (AVL_ADDR == ADDR_W'(i)) rdata_d = key_q[i];
    for (int i = 0; i < MSG_WORDS; i++) begin
      if (AVL_ADDR == ADDR_W'(KEY_WORDS + i))             rdata_d = msg_q[i];
      if (AVL_ADDR == ADDR_W'(KEY_WORDS + MSG_WORDS + i)) rdata_d = res_q[i];
    end
    if (AVL_ADDR == CTRL_ADDR)   rdata_d = DATA_W'({irq_en_q, 1'b0});
    if (AVL_ADDR == STATUS_ADDR) rdata_d = DATA_W'({err_q, busy, done});
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
      irq_q    <= done & irq_en_q;
      if (rd_en) rdata_q <= rdata_d;
    end
  end

  assign AVL_READDATA = rdata_q;
  assign CORE_START   = start_q;
  assign IRQ          = irq_q;
  assign EXPORT_DATA  = {msg_q[0][DATA_W-1 -: HALF], msg_q[MSG_WORDS-1][HALF-1:0]};

endmodule

// File: tb/tb_avalon_crypto_regbank.sv
// Directed self-checking bench for avalon_crypto_regbank with default parameters.
module tb_avalon_crypto_regbank;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          avl_read = 1'b0, avl_write = 1'b0, avl_cs = 1'b0;
  logic [3:0]    avl_be = '0;
  logic [3:0]    avl_addr = '0;
  logic [31:0]   avl_wdata = '0;
  logic [31:0]   avl_rdata;
  logic [127:0]  core_key, core_msg;
  logic          core_start;
  logic [127:0]  core_result = '0;
  logic          core_done = 1'b0;
  logic          irq;
  logic [31:0]   export_data;

  int checks = 0;
  int passes = 0;
  int start_cnt = 0;
  logic [31:0] rd;

  localparam logic [3:0] A_CTRL = 4'd14, A_STATUS = 4'd15, A_RES0 = 4'd8;

  avalon_crypto_regbank dut (
    .CLK(clk), .RESET_N(rst_n), .AVL_READ(avl_read), .AVL_WRITE(avl_write),
    .AVL_CS(avl_cs), .AVL_BYTE_EN(avl_be), .AVL_ADDR(avl_addr),
    .AVL_WRITEDATA(avl_wdata), .AVL_READDATA(avl_rdata), .CORE_KEY(core_key),
    .CORE_MSG(core_msg), .CORE_START(core_start), .CORE_RESULT(core_result),
    .CORE_DONE(core_done), .IRQ(irq), .EXPORT_DATA(export_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (core_start) start_cnt++;

  task automatic avl_wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = a; avl_wdata = d; avl_be = be;
    @(negedge clk);
    avl_cs = 1'b0; avl_write = 1'b0; avl_be = '0;
    $display("write addr=%0d data=%08h be=%b", a, d, be);
  endtask

  task automatic avl_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    avl_cs = 1'b1; avl_read = 1'b1; avl_addr = a;
    @(negedge clk);
    avl_cs = 1'b0; avl_read = 1'b0;
    d = avl_rdata;
    $display("read  addr=%0d data=%08h", a, d);
  endtask

  task automatic pulse_done(input logic [127:0] res);
    @(negedge clk);
    core_done = 1'b1; core_result = res;
    @(negedge clk);
    core_done = 1'b0;
    $display("core_done pulse result=%032h", res);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (avl_rdata !== 32'h0) $display("FAIL reset_rdata got=%08h exp=0", avl_rdata); else passes++;
    checks++; if ({core_start, irq} !== 2'b00) $display("FAIL reset_start_irq got=%b exp=00", {core_start, irq}); else passes++;
    checks++; if (export_data !== 32'h0) $display("FAIL reset_export got=%08h exp=0", export_data); else passes++;
    checks++; if ({core_key, core_msg} !== 256'h0) $display("FAIL reset_key_msg got nonzero exp=0"); else passes++;
    rst_n = 1'b1;
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) $display("FAIL reset_status got=%08h exp=0", rd); else passes++;
  endtask

  task automatic test_write_readback;
    logic [31:0] msgs [4];
    msgs[0] = 32'hDAEC3055; msgs[1] = 32'h11111111; msgs[2] = 32'h22222222; msgs[3] = 32'hDF058AD1;
    avl_wr(4'd0, 32'h00010203, 4'hF);
    for (int i = 0; i < 4; i++) avl_wr(4'(4 + i), msgs[i], 4'hF);
    avl_rd(4'd0, rd);
    checks++; if (rd !== 32'h00010203) $display("FAIL key0_readback got=%08h exp=00010203", rd); else passes++;
    for (int i = 0; i < 4; i++) begin
      avl_rd(4'(4 + i), rd);
      checks++; if (rd !== msgs[i]) $display("FAIL msg%0d_readback got=%08h exp=%08h", i, rd, msgs[i]); else passes++;
    end
    checks++; if (export_data !== 32'hDAEC8AD1) $display("FAIL export_data got=%08h exp=DAEC8AD1", export_data); else passes++;
    checks++; if (core_key[127:96] !== 32'h00010203) $display("FAIL core_key_w0 got=%08h exp=00010203", core_key[127:96]); else passes++;
    checks++; if (core_msg[31:0] !== 32'hDF058AD1) $display("FAIL core_msg_w3 got=%08h exp=DF058AD1", core_msg[31:0]); else passes++;
  endtask

  task automatic test_byte_en;
    avl_wr(4'd1, 32'hAABBCCDD, 4'b0100);
    avl_rd(4'd1, rd);
    checks++; if (rd !== 32'h00BB0000) $display("FAIL byte_en_key1 got=%08h exp=00BB0000", rd); else passes++;
    avl_wr(4'd12, 32'h12345678, 4'hF);
    avl_rd(4'd12, rd);
    checks++; if (rd !== 32'h0) $display("FAIL unmapped_read got=%08h exp=0", rd); else passes++;
  endtask

  task automatic test_launch;
    start_cnt = 0;
    avl_wr(A_CTRL, 32'h3, 4'h1);
    checks++; if (core_start !== 1'b1) $display("FAIL start_pulse_high got=%b exp=1", core_start); else passes++;
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h2) $display("FAIL status_busy got=%08h exp=2", rd); else passes++;
    checks++; if (start_cnt !== 1) $display("FAIL start_pulse_width got=%0d exp=1", start_cnt); else passes++;
    avl_rd(A_CTRL, rd);
    checks++; if (rd !== 32'h2) $display("FAIL ctrl_readback got=%08h exp=2", rd); else passes++;
    repeat (6) @(negedge clk);
    pulse_done({32'h1234ABCD, 32'h5, 32'h6, 32'h7});
    checks++; if (irq !== 1'b0) $display("FAIL irq_delay got=%b exp=0", irq); else passes++;
    @(negedge clk);
    checks++; if (irq !== 1'b1) $display("FAIL irq_rise got=%b exp=1", irq); else passes++;
    avl_rd(A_RES0, rd);
    checks++; if (rd !== 32'h1234ABCD) $display("FAIL result0 got=%08h exp=1234ABCD", rd); else passes++;
    avl_rd(4'd11, rd);
    checks++; if (rd !== 32'h7) $display("FAIL result3 got=%08h exp=7", rd); else passes++;
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h1) $display("FAIL status_done got=%08h exp=1", rd); else passes++;
    avl_wr(A_STATUS, 32'h1, 4'h1);
    @(negedge clk);
    checks++; if (irq !== 1'b0) $display("FAIL irq_fall got=%b exp=0", irq); else passes++;
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) $display("FAIL status_cleared got=%08h exp=0", rd); else passes++;
  endtask

  task automatic test_protection;
    start_cnt = 0;
    avl_wr(A_CTRL, 32'h1, 4'h1);
    avl_wr(4'd4, 32'hFFFFFFFF, 4'hF);
    avl_wr(A_CTRL, 32'h1, 4'h1);
    avl_rd(4'd4, rd);
    checks++; if (rd !== 32'hDAEC3055) $display("FAIL msg0_protected got=%08h exp=DAEC3055", rd); else passes++;
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h6) $display("FAIL status_err_busy got=%08h exp=6", rd); else passes++;
    checks++; if (start_cnt !== 1) $display("FAIL no_second_start got=%0d exp=1", start_cnt); else passes++;
    avl_wr(A_RES0, 32'h0, 4'hF);
    avl_rd(A_RES0, rd);
    checks++; if (rd !== 32'h1234ABCD) $display("FAIL result_readonly got=%08h exp=1234ABCD", rd); else passes++;
    pulse_done({32'hCAFEF00D, 96'h0});
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h5) $display("FAIL status_err_done got=%08h exp=5", rd); else passes++;
    avl_wr(A_STATUS, 32'h4, 4'h1);
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h1) $display("FAIL err_w1c got=%08h exp=1", rd); else passes++;
  endtask

  task automatic test_back_to_back;
    avl_wr(A_CTRL, 32'h1, 4'h1);
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h2) $display("FAIL restart_from_done got=%08h exp=2", rd); else passes++;
    checks++; if (start_cnt !== 2) $display("FAIL restart_pulse got=%0d exp=2", start_cnt); else passes++;
  endtask

  task automatic test_reset_mid_run;
    start_cnt = 0;
    avl_wr(A_CTRL, 32'h3, 4'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start_cnt = 0;
    avl_rd(4'd0, rd);
    checks++; if (rd !== 32'h0) $display("FAIL rst_key0 got=%08h exp=0", rd); else passes++;
    avl_rd(4'd4, rd);
    checks++; if (rd !== 32'h0) $display("FAIL rst_msg0 got=%08h exp=0", rd); else passes++;
    avl_rd(A_RES0, rd);
    checks++; if (rd !== 32'h0) $display("FAIL rst_result0 got=%08h exp=0", rd); else passes++;
    avl_rd(A_CTRL, rd);
    checks++; if (rd !== 32'h0) $display("FAIL rst_ctrl got=%08h exp=0", rd); else passes++;
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) $display("FAIL rst_status_idle got=%08h exp=0", rd); else passes++;
    pulse_done({32'hDEADBEEF, 96'h0});
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h0) $display("FAIL done_ignored_idle got=%08h exp=0", rd); else passes++;
    avl_rd(A_RES0, rd);
    checks++; if (rd !== 32'h0) $display("FAIL no_capture_idle got=%08h exp=0", rd); else passes++;
    checks++; if (start_cnt !== 0) $display("FAIL no_start_after_rst got=%0d exp=0", start_cnt); else passes++;
  endtask

  task automatic test_collision;
    avl_wr(A_CTRL, 32'h1, 4'h1);
    @(negedge clk);
    avl_cs = 1'b1; avl_write = 1'b1; avl_addr = A_STATUS; avl_wdata = 32'h1; avl_be = 4'h1;
    core_done = 1'b1; core_result = {32'h0BADCAFE, 96'h0};
    @(negedge clk);
    avl_cs = 1'b0; avl_write = 1'b0; avl_be = '0; core_done = 1'b0;
    $display("collision: status w1c with core_done");
    avl_rd(A_STATUS, rd);
    checks++; if (rd !== 32'h1) $display("FAIL collision_done got=%08h exp=1", rd); else passes++;
    avl_rd(A_RES0, rd);
    checks++; if (rd !== 32'h0BADCAFE) $display("FAIL collision_result got=%08h exp=0BADCAFE", rd); else passes++;
  endtask

  initial begin
    test_reset();
    test_write_readback();
    test_byte_en();
    test_launch();
    test_protection();
    test_back_to_back();
    test_reset_mid_run();
    test_collision();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
